// File: rtl/obstacle_vertex_streamer_pkg.sv
// Shared types and geometry helpers for the obstacle vertex streamer.
// The table layout is a fixed stride of (max vertices + 1) words per slot:
// one header word holding the vertex count, followed by the vertex words.
package obstacle_pkg;

    localparam int WORLD_BITS_DEFAULT   = 32;
    localparam int MAX_VERTICES_DEFAULT = 8;

    // One vertex word as stored in memory: x in the upper half.
    typedef struct packed {
        logic signed [WORLD_BITS_DEFAULT-1:0] x;
        logic signed [WORLD_BITS_DEFAULT-1:0] y;
    } vertex_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_HWAIT,
        ST_STREAM,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE
    } streamer_state_t;

    // Words occupied by one slot (header + vertex capacity).
    function automatic int slot_stride(input int max_vertices);
        return max_vertices + 1;
    endfunction

    // Width of the vertex-count field in the header word.
    function automatic int hdr_count_bits(input int max_vertices);
        return $clog2(max_vertices + 1);
    endfunction

    localparam int SLOT_STRIDE    = slot_stride(MAX_VERTICES_DEFAULT);
    localparam int HDR_COUNT_BITS = hdr_count_bits(MAX_VERTICES_DEFAULT);

endpackage

// File: rtl/obstacle_vertex_streamer_addr_gen.sv
// Address generator for the obstacle table walk: owns the slot index and the
// in-slot vertex offset, and keeps the read address registered as
// slot * stride + offset so it can drive the memory directly.
module obstacle_addr_gen
    import obstacle_pkg::*;
#(
    parameter int NUM_OBSTACLES    = 8,
    parameter int MAX_NUM_VERTICES = 8,
    parameter int ADDR_BITS        = $clog2(NUM_OBSTACLES * (MAX_NUM_VERTICES + 1)),
    parameter int CNT_BITS         = hdr_count_bits(MAX_NUM_VERTICES),
    parameter int SLOT_BITS        = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 slot_advance,
    input  logic                 vtx_advance,
    input  logic [CNT_BITS-1:0]  vtx_count,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 last_slot,
    output logic                 last_vertex
);

    localparam int STRIDE = slot_stride(MAX_NUM_VERTICES);
    localparam logic [SLOT_BITS-1:0] LAST_SLOT_IDX = SLOT_BITS'(NUM_OBSTACLES - 1);

    logic [SLOT_BITS-1:0] slot;
    logic [CNT_BITS-1:0]  offset;

    function automatic logic [ADDR_BITS-1:0] form_addr(input logic [SLOT_BITS-1:0] s,
                                                       input logic [CNT_BITS-1:0]  o);
        return ADDR_BITS'(int'(s) * STRIDE + int'(o));
    endfunction

    // Slot/offset counters with the address updated in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= '0;
            offset <= '0;
            addr   <= '0;
        end else if (frame_start) begin
            slot   <= '0;
            offset <= '0;
            addr   <= '0;
        end else if (slot_advance) begin
            slot   <= slot + 1'b1;
            offset <= '0;
            addr   <= form_addr(slot + 1'b1, '0);
        end else if (vtx_advance) begin
            offset <= offset + 1'b1;
            addr   <= form_addr(slot, offset + 1'b1);
        end
    end

    assign last_slot   = (slot == LAST_SLOT_IDX);
    assign last_vertex = (offset == vtx_count);

endmodule

// File: rtl/obstacle_vertex_streamer.sv
// Walks the obstacle table once per frame and streams every non-empty slot
// as a contiguous valid burst of vertices, then pulses done_out.
// Optional feature macro: STREAMER_CLOSE_POLY_EN -- appends the first vertex
// of each burst as an extra final cycle so the emitted polygon is closed.
module obstacle_vertex_streamer
    import obstacle_pkg::*;
#(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 8,
    parameter int NUM_OBSTACLES    = 8,
    parameter int ADDR_BITS        = $clog2(NUM_OBSTACLES * (MAX_NUM_VERTICES + 1))
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         start_in,
    output logic                         rd_en_out,
    output logic [ADDR_BITS-1:0]         rd_addr_out,
    input  logic [2*WORLD_BITS-1:0]      rd_data_in,
    output logic                         valid_out,
    output logic signed [WORLD_BITS-1:0] x_out,
    output logic signed [WORLD_BITS-1:0] y_out,
    output logic                         done_out,
    output logic                         busy_out
);

    localparam int CNT_BITS  = hdr_count_bits(MAX_NUM_VERTICES);
    localparam int SLOT_BITS = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1;
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_NUM_VERTICES);

    streamer_state_t     state;
    logic [CNT_BITS-1:0] vtx_count;
    logic [CNT_BITS-1:0] hdr_count;
    logic                vtx_rd;        // a vertex read is on the bus this cycle
    logic                vtx_data_vld;  // rd_data_in carries a vertex this cycle
    logic                drain_busy;
    logic                frame_start;
    logic                slot_advance;
    logic                vtx_advance;
    logic                last_slot;
    logic                last_vertex;

    assign hdr_count = rd_data_in[CNT_BITS-1:0];

    obstacle_addr_gen #(
        .NUM_OBSTACLES   (NUM_OBSTACLES),
        .MAX_NUM_VERTICES(MAX_NUM_VERTICES),
        .ADDR_BITS       (ADDR_BITS),
        .CNT_BITS        (CNT_BITS),
        .SLOT_BITS       (SLOT_BITS)
    ) u_addr_gen (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .frame_start (frame_start),
        .slot_advance(slot_advance),
        .vtx_advance (vtx_advance),
        .vtx_count   (vtx_count),
        .addr        (rd_addr_out),
        .last_slot   (last_slot),
        .last_vertex (last_vertex)
    );

    // Address-generator commands decoded from the current state.
    always_comb begin
        frame_start  = 1'b0;
        slot_advance = 1'b0;
        vtx_advance  = 1'b0;
        case (state)
            ST_IDLE:   frame_start  = start_in;
            ST_HWAIT:  vtx_advance  = (hdr_count != '0);
            ST_STREAM: vtx_advance  = !last_vertex;
            ST_NEXT:   slot_advance = !last_slot;
            default:   ;
        endcase
    end

    // Frame sequencer; read strobe and status outputs are set for the next cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            vtx_count <= '0;
            rd_en_out <= 1'b0;
            vtx_rd    <= 1'b0;
            done_out  <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            rd_en_out <= 1'b0;
            vtx_rd    <= 1'b0;
            done_out  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        state     <= ST_HDR;
                        rd_en_out <= 1'b1;
                        busy_out  <= 1'b1;
                    end
                end
                ST_HDR: state <= ST_HWAIT;
                ST_HWAIT: begin
                    if (hdr_count == '0) begin
                        state <= ST_NEXT;
                    end else begin
                        vtx_count <= (hdr_count > MAX_CNT) ? MAX_CNT : hdr_count;
                        state     <= ST_STREAM;
                        rd_en_out <= 1'b1;
                        vtx_rd    <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (last_vertex) begin
                        state <= ST_DRAIN;
                    end else begin
                        rd_en_out <= 1'b1;
                        vtx_rd    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!drain_busy) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (last_slot) begin
                        state    <= ST_DONE;
                        done_out <= 1'b1;
                    end else begin
                        state     <= ST_HDR;
                        rd_en_out <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy_out <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef STREAMER_CLOSE_POLY_EN
    logic                      last_data_vld;
    logic                      close_stage;
    logic [2*WORLD_BITS-1:0]   first_vertex;

    // Track the last vertex through the read latency and latch each burst's
    // first vertex (first data while the output is idle) for the closing cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_data_vld <= 1'b0;
            close_stage   <= 1'b0;
            first_vertex  <= '0;
        end else begin
            last_data_vld <= vtx_rd && last_vertex;
            close_stage   <= last_data_vld;
            if (vtx_data_vld && !valid_out) first_vertex <= rd_data_in;
        end
    end

    assign drain_busy = vtx_data_vld || close_stage;
`else
    assign drain_busy = vtx_data_vld;
`endif

    // Output register: vertex data one cycle after it arrives, held otherwise.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vtx_data_vld <= 1'b0;
            valid_out    <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
        end else begin
            vtx_data_vld <= vtx_rd;
            valid_out    <= vtx_data_vld;
            if (vtx_data_vld) {x_out, y_out} <= rd_data_in;
`ifdef STREAMER_CLOSE_POLY_EN
            if (close_stage) begin
                valid_out      <= 1'b1;
                {x_out, y_out} <= first_vertex;
            end
`endif
        end
    end

endmodule

// File: tb/tb_obstacle_vertex_streamer.sv
// Self-checking bench for obstacle_vertex_streamer: table-driven frames,
// hand-written reset/abort/ignore sequences, and randomized tables checked
// against a slot-by-slot model of the expected stream.
module tb_obstacle_vertex_streamer;
    import obstacle_pkg::*;

    localparam int W    = 32;
    localparam int MAXV = 8;
    localparam int NOBS = 8;
    localparam int S    = MAXV + 1;
    localparam int AW   = $clog2(NOBS * S);
`ifdef STREAMER_CLOSE_POLY_EN
    localparam int CLOSE_EXTRA = 1;
`else
    localparam int CLOSE_EXTRA = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start_in = 1'b0;
    logic                rd_en_out;
    logic [AW-1:0]       rd_addr_out;
    logic [2*W-1:0]      rd_data = '0;
    logic                valid_out;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic                done_out;
    logic                busy_out;

    always #5 clk = ~clk;

    obstacle_vertex_streamer #(
        .WORLD_BITS      (W),
        .MAX_NUM_VERTICES(MAXV),
        .NUM_OBSTACLES   (NOBS)
    ) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .start_in   (start_in),
        .rd_en_out  (rd_en_out),
        .rd_addr_out(rd_addr_out),
        .rd_data_in (rd_data),
        .valid_out  (valid_out),
        .x_out      (x_out),
        .y_out      (y_out),
        .done_out   (done_out),
        .busy_out   (busy_out)
    );

    // Obstacle storage: synchronous single-port read memory.
    logic [2*W-1:0] mem [0:NOBS*S-1];
    always @(posedge clk) begin
        if (rd_en_out)
            rd_data <= (int'(rd_addr_out) < NOBS * S) ? mem[int'(rd_addr_out)] : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    int checks = 0;
    int failures = 0;

    int unsigned    exp_addr[$];
    logic [2*W-1:0] exp_vtx[$];
    int unsigned    exp_len[$];
    int unsigned    model_len[$];
    int             exp_first_rel;

    typedef struct packed {
        logic [31:0]        hdr;      // nibble i = header count of slot i
        logic [31:0]        lens;     // nibble j = length of burst j (without closing cycle)
        logic [3:0]         nlen;
        logic signed [15:0] done_rel; // -1 = not checked
        logic [1:0]         mode;     // 0 plain, 1 start mid-frame, 2 start in DONE cycle
    } vec_t;

    vec_t vecs[6];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic fill_mem(input logic [31:0] hdr_nib);
        for (int s = 0; s < NOBS; s++)
            for (int k = 0; k < S; k++)
                mem[s*S+k] = {$urandom, $urandom};
        for (int s = 0; s < NOBS; s++)
            mem[s*S][3:0] = hdr_nib[4*s +: 4];
    endtask

    // Expected address sequence, vertex stream and burst lengths from the table contents.
    task automatic build_model();
        int n;
        int lead;
        bit seen;
        exp_addr.delete();
        exp_vtx.delete();
        model_len.delete();
        exp_first_rel = -1;
        lead = 0;
        seen = 1'b0;
        for (int s = 0; s < NOBS; s++) begin
            n = int'(mem[s*S][3:0]);
            if (n > MAXV) n = MAXV;
            exp_addr.push_back(s * S);
            if (n == 0) begin
                if (!seen) lead++;
            end else begin
                seen = 1'b1;
                for (int k = 1; k <= n; k++) begin
                    exp_addr.push_back(s * S + k);
                    exp_vtx.push_back(mem[s*S+k]);
                end
                if (CLOSE_EXTRA != 0) exp_vtx.push_back(mem[s*S+1]);
                model_len.push_back(n + CLOSE_EXTRA);
            end
        end
        // start seen at t: first vertex at t+5, plus 3 cycles per empty slot before it
        if (seen) exp_first_rel = 5 + 3 * lead;
    endtask

    task automatic run_frame(input string tag, input int mode, input int exp_done_rel);
        int rel, first_valid_rel, last_valid_rel, done_rel, done_cnt, cur_len;
        int last_fall_rel, min_gap, addr_err, vtx_err, busy_err, len_err, rd_after;
        bit finished, valid_at_done;
        int unsigned obs_len[$];
        vertex_t got, want;
        first_valid_rel = -1; last_valid_rel = -1; done_rel = -1; done_cnt = 0;
        cur_len = 0; last_fall_rel = -1; min_gap = 1000; addr_err = 0; vtx_err = 0;
        busy_err = 0; len_err = 0; finished = 1'b0; valid_at_done = 1'b0;

        @(negedge clk) start_in = 1'b1;
        @(negedge clk) start_in = 1'b0;
        rel = 1;
        check({tag, " hdr_rd_en"}, 64'(rd_en_out), 64'd1);
        check({tag, " hdr_addr"}, 64'(rd_addr_out), 64'd0);

        while (!finished && rel < 600) begin
            if (rd_en_out) begin
                if (exp_addr.size() == 0) addr_err++;
                else if (exp_addr.pop_front() != int'(rd_addr_out)) addr_err++;
            end
            if (valid_out) begin
                if (first_valid_rel < 0) first_valid_rel = rel;
                if (cur_len == 0 && last_fall_rel >= 0 && rel - last_fall_rel < min_gap)
                    min_gap = rel - last_fall_rel;
                cur_len++;
                last_valid_rel = rel;
                got.x = x_out;
                got.y = y_out;
                if (exp_vtx.size() == 0) vtx_err++;
                else begin
                    want = exp_vtx.pop_front();
                    if (got != want) vtx_err++;
                end
            end else if (cur_len > 0) begin
                obs_len.push_back(cur_len);
                cur_len = 0;
                last_fall_rel = rel;
            end
            if (done_out) begin
                done_cnt++;
                if (done_rel < 0) done_rel = rel;
                if (valid_out) valid_at_done = 1'b1;
                if (mode == 2) start_in = 1'b1;
            end
            if (done_rel >= 0 && rel == done_rel + 1) begin
                if (busy_out) busy_err++;
                start_in = 1'b0;
                finished = 1'b1;
            end else if (!busy_out) begin
                busy_err++;
            end
            if (mode == 1 && rel == 10) start_in = 1'b1;
            if (mode == 1 && rel == 11) start_in = 1'b0;
            if (!finished) begin
                @(negedge clk);
                rel++;
            end
        end
        start_in = 1'b0;

        check({tag, " finished_in_budget"}, 64'(finished), 64'd1);
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " valid_low_at_done"}, 64'(valid_at_done), 64'd0);
        check({tag, " busy_profile_errs"}, 64'(busy_err), 64'd0);
        check({tag, " addr_errs"}, 64'(addr_err), 64'd0);
        check({tag, " addr_leftover"}, 64'(exp_addr.size()), 64'd0);
        check({tag, " vertex_errs"}, 64'(vtx_err), 64'd0);
        check({tag, " vertex_leftover"}, 64'(exp_vtx.size()), 64'd0);
        check({tag, " burst_count"}, 64'(obs_len.size()), 64'(exp_len.size()));
        for (int i = 0; i < exp_len.size(); i++)
            if (i >= obs_len.size() || obs_len[i] != exp_len[i]) len_err++;
        check({tag, " burst_len_errs"}, 64'(len_err), 64'd0);
        if (exp_first_rel >= 0)
            check({tag, " first_valid_cycle"}, 64'(first_valid_rel), 64'(exp_first_rel));
        if (last_valid_rel >= 0)
            check({tag, " done_after_last_valid_ge2"}, 64'(done_rel - last_valid_rel >= 2), 64'd1);
        if (obs_len.size() > 1)
            check({tag, " min_gap_ge3"}, 64'(min_gap >= 3), 64'd1);
        if (exp_done_rel >= 0)
            check({tag, " done_cycle"}, 64'(done_rel), 64'(exp_done_rel));
        if (mode == 2) begin
            rd_after = 0;
            repeat (10) begin
                @(negedge clk);
                if (rd_en_out || busy_out) rd_after++;
            end
            check({tag, " start_in_done_ignored"}, 64'(rd_after), 64'd0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int waited, bad;
        logic [31:0] hdr;

        vecs[0] = '{hdr: 32'h0000_0003, lens: 32'h0000_0003, nlen: 4'd1, done_rel: -16'sd1, mode: 2'd0};
        vecs[1] = '{hdr: 32'h3201_0854, lens: 32'h0032_1854, nlen: 4'd6, done_rel: -16'sd1, mode: 2'd1};
        vecs[2] = '{hdr: 32'h0000_0000, lens: 32'h0000_0000, nlen: 4'd0, done_rel: 16'sd25,  mode: 2'd2};
        vecs[3] = '{hdr: 32'h9000_000F, lens: 32'h0000_0088, nlen: 4'd2, done_rel: -16'sd1, mode: 2'd0};
        vecs[4] = '{hdr: 32'h8888_8888, lens: 32'h8888_8888, nlen: 4'd8, done_rel: -16'sd1, mode: 2'd1};
        vecs[5] = '{hdr: 32'h1000_0000, lens: 32'h0000_0001, nlen: 4'd1, done_rel: -16'sd1, mode: 2'd2};

        // reset state
        repeat (3) @(negedge clk);
        check("rst valid", 64'(valid_out), 64'd0);
        check("rst x", 64'(x_out), 64'd0);
        check("rst y", 64'(y_out), 64'd0);
        check("rst done", 64'(done_out), 64'd0);
        check("rst busy", 64'(busy_out), 64'd0);
        check("rst rd_en", 64'(rd_en_out), 64'd0);
        check("rst rd_addr", 64'(rd_addr_out), 64'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (rd_en_out || busy_out || valid_out) bad++;
        end
        check("idle_no_read", 64'(bad), 64'd0);

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            fill_mem(vecs[i].hdr);
            if (i == 0) begin
                mem[1] = {32'h0000_00AA, 32'h0000_00BB};
                mem[2] = {32'h0000_00CC, 32'h0000_00DD};
                mem[3] = {32'h0000_00EE, 32'h0000_00FF};
            end
            build_model();
            exp_len.delete();
            for (int j = 0; j < int'(vecs[i].nlen); j++)
                exp_len.push_back(int'(vecs[i].lens[4*j +: 4]) + CLOSE_EXTRA);
            run_frame($sformatf("vec%0d", i), int'(vecs[i].mode), int'(vecs[i].done_rel));
        end

        // abort mid-burst with asynchronous reset
        fill_mem(32'h0000_0008);
        @(negedge clk) start_in = 1'b1;
        @(negedge clk) start_in = 1'b0;
        waited = 0;
        while (!valid_out && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("abort saw_valid", 64'(valid_out), 64'd1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort valid_async", 64'(valid_out), 64'd0);
        check("abort busy_async", 64'(busy_out), 64'd0);
        check("abort rd_en_async", 64'(rd_en_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_out || rd_en_out || valid_out) bad++;
        end
        check("abort no_done_no_activity", 64'(bad), 64'd0);

        // clean frame after abort
        fill_mem(32'h0502_0003);
        build_model();
        exp_len = model_len;
        run_frame("post_abort", 0, -1);

        // randomized tables against the model
        for (int r = 0; r < 6; r++) begin
            hdr = '0;
            for (int s = 0; s < NOBS; s++)
                hdr[4*s +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            fill_mem(hdr);
            build_model();
            exp_len = model_len;
            run_frame($sformatf("rand%0d", r), int'($urandom_range(0, 1)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_vertex_streamer.md
# obstacle_vertex_streamer

Streams the obstacle table out, one vertex per cycle, as the valid/x/y/done vertex stream that `get_obstacles_on_screen` consumes. It sits between the obstacle storage (a synchronous single-port read memory) and the on-screen filter. It walks every obstacle slot once per frame, emits each non-empty obstacle as a contiguous valid burst, and pulses `done_out` once the frame is complete.

## Interface
- `WORLD_BITS`, 32, signed width of each coordinate.
- `MAX_NUM_VERTICES`, 8, vertex capacity per obstacle slot.
- `NUM_OBSTACLES`, 8, number of slots in the table.
- `ADDR_BITS`, `$clog2(NUM_OBSTACLES*(MAX_NUM_VERTICES+1))`, memory address width.

- `clk_in` in 1: single clock; everything sits in this domain.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `start_in` in 1: one-cycle pulse that begins a frame; ignored while `busy_out` is high.
- `rd_en_out` out 1: memory read strobe.
- `rd_addr_out` out ADDR_BITS: memory read address.
- `rd_data_in` in 2*WORLD_BITS: read data, valid one cycle after `rd_en_out`; vertex words are {x, y}, with x in the upper half.
- `valid_out` out 1: vertex valid.
- `x_out` out WORLD_BITS signed: vertex x.
- `y_out` out WORLD_BITS signed: vertex y.
- `done_out` out 1: one-cycle frame-complete pulse.
- `busy_out` out 1: frame in progress.

## Operation
- Memory layout: fixed stride S = MAX_NUM_VERTICES+1. Slot i header is at address i*S; its low $clog2(MAX_NUM_VERTICES+1) bits hold the vertex count N. Vertices are at i*S+1 … i*S+N.
- FSM states:
  - IDLE → HDR on `start_in`.
  - HDR issues the header read → HWAIT.
  - HWAIT captures N:
    - N=0: empty slot → NEXT.
    - N>MAX_NUM_VERTICES: clamp to MAX_NUM_VERTICES → STREAM.
    - otherwise → STREAM.
  - STREAM issues N consecutive vertex reads, one per cycle → DRAIN.
  - DRAIN waits until the last vertex has been emitted → NEXT.
  - NEXT: if the slot index is NUM_OBSTACLES-1 → DONE, else increment the slot index → HDR.
  - DONE pulses `done_out` → IDLE.
- Every output is registered. Vertex data goes to `x_out`/`y_out` one cycle after it arrives on `rd_data_in`.
- `x_out`/`y_out` hold their last value when `valid_out` is low.
- There is no backpressure. The consumer must accept one vertex per cycle.
- Reset values: all outputs 0, state IDLE, slot index 0.
- Reset asserted mid-frame aborts immediately. No `done_out` is produced for the aborted frame.
- `start_in` asserted in the DONE cycle is ignored.

## Timing
- `start_in` sampled at cycle t:
  - header read (`rd_en_out`=1, `rd_addr_out`=0) at t+1;
  - header data at t+2;
  - first vertex address at t+3;
  - first `valid_out` at t+5.
- Within an obstacle, `valid_out` stays high for exactly N consecutive cycles.
- Between bursts there are at least 3 idle cycles (header round trip), so each obstacle is delimited by `valid_out` falling.
- Each empty slot costs 3 cycles (HDR, HWAIT, NEXT) with no output.
- `done_out` is high exactly 1 cycle, 2 or more cycles after the final `valid_out`, with `valid_out` low.
- `busy_out` rises at t+1 and falls in the cycle after `done_out`.

## Configuration
- `STREAMER_CLOSE_POLY_EN`:
  - Defined: each non-empty burst is N+1 cycles long. The extra final cycle re-emits the first vertex, which is latched on its first emission, so the polygon closes.
  - Undefined: bursts are exactly N cycles and the first-vertex latch is not instantiated.

## Structure
- `obstacle_pkg` holds:
  - `vertex_t` (packed struct {x, y}, signed WORLD_BITS each);
  - `streamer_state_t` enum;
  - the slot-stride and header-count-width constants.
- One sub-module, `obstacle_addr_gen`, owns the slot index, the vertex counter and address formation (slot*S + offset). It reports `last_slot` and `last_vertex` to the FSM.

## Test plan
- **Reset:** hold `rst_n_in`=0 → all outputs 0. Release, no `start_in` → no `rd_en_out`.
- **Single obstacle:** NUM_OBSTACLES=2, slot0 N=3 with vertices (0xAA,0xBB), (0xCC,0xDD), (0xEE,0xFF), slot1 N=0, `start_in` at t.
  - `valid_out` high t+5…t+7 with those three vertices in order.
  - `done_out` is a single pulse afterwards.
  - `rd_addr_out` takes the values 0,1,2,3,9.
- **Full table:** slots N=4,5,8,…; all bursts are contiguous with the exact lengths; at least 3 idle cycles between bursts; exactly one `done_out`.
- **Clamp:** header N=15 with MAX_NUM_VERTICES=8 → burst of 8, addresses stay inside the slot.
- **Close polygon:** with `STREAMER_CLOSE_POLY_EN`, N=3 (0xA0,0xB0)… → 4-cycle burst whose last vertex is (0xA0,0xB0).
- **Abort and ignore:**
  - `rst_n_in` pulsed low mid-burst → `valid_out` drops asynchronously, no `done_out`.
  - A new `start_in` afterwards runs a clean frame.
  - `start_in` while busy has no effect.
